// File: rtl/shift_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_counter_pkg
// Brief    : Shared mode constants and sizing/reset helpers for shift_counter_gen.
// Revision : 1.0 - initial release
// ============================================================================
package shift_counter_pkg;

    localparam int MODE_JOHNSON = 0;
    localparam int MODE_RING    = 1;

    function automatic int idx_width(input int width);
        return $clog2(2 * width);
    endfunction

    // Johnson starts from all zeros; ring starts with the token in bit 0.
    function automatic logic [31:0] reset_value(input int width, input int mode);
        logic [31:0] v;
        v = (mode == MODE_RING) ? 32'd1 : 32'd0;
        if (width < 1) v = '0;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_counter_decode.sv
`default_nettype none
// ============================================================================
// Module   : shift_counter_decode
// Brief    : Combinational decode of a ring/Johnson state to index + legality.
// Revision : 1.0 - initial release
// ============================================================================
module shift_counter_decode
    import shift_counter_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int MODE  = MODE_JOHNSON,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] count,
    output logic [IDX_W-1:0] idx,
    output logic             illegal
);

    generate
        if (MODE == MODE_RING) begin : g_ring
            logic [IDX_W-1:0] w_ones;
            logic [IDX_W-1:0] w_pos;

            always_comb begin
                w_ones = '0;
                w_pos  = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (count[i]) begin
                        w_ones = w_ones + 1'b1;
                        w_pos  = IDX_W'(i);
                    end
                end
            end

            assign illegal = (w_ones != IDX_W'(1));
            assign idx     = illegal ? '0 : w_pos;
        end else begin : g_johnson
            // 2*WIDTH may alias to 0 in IDX_W bits; modular subtraction still gives the index.
            localparam logic [IDX_W-1:0] c_TWO_W = IDX_W'(2 * WIDTH);
            logic [IDX_W-1:0] w_ones;
            logic [IDX_W-1:0] w_edges;

            always_comb begin
                w_ones  = '0;
                w_edges = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (count[i]) w_ones = w_ones + 1'b1;
                end
                for (int i = 0; i < WIDTH - 1; i++) begin
                    if (count[i] != count[i+1]) w_edges = w_edges + 1'b1;
                end
            end

            assign illegal = (w_edges > IDX_W'(1));
            assign idx     = illegal            ? '0 :
                             count[WIDTH-1]     ? (c_TWO_W - w_ones) : w_ones;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/shift_counter_gen.sv
`default_nettype none
// ============================================================================
// Module   : shift_counter_gen
// Brief    : Parametrised Johnson/ring shift counter with load, direction,
//            index decode, wrap pulse and illegal-state flag.
//            Optional: SHIFT_COUNTER_AUTOCORRECT_EN resets on stepping an
//            illegal state.
// Revision : 1.0 - initial release
// ============================================================================
module shift_counter_gen
    import shift_counter_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int MODE  = MODE_JOHNSON,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [IDX_W-1:0] idx,
    output logic             wrap,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] c_RESET = WIDTH'(reset_value(WIDTH, MODE));
    localparam logic [IDX_W-1:0] c_LAST  =
        IDX_W'((MODE == MODE_RING) ? (WIDTH - 1) : (2 * WIDTH - 1));

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_step;
    logic [IDX_W-1:0] w_idx;
    logic             w_illegal;
    logic             w_wrap_hit;

    generate
        if (MODE == MODE_RING) begin : g_ring_step
            assign w_step = dir ? {r_count[0], r_count[WIDTH-1:1]}
                                : {r_count[WIDTH-2:0], r_count[WIDTH-1]};
        end else begin : g_johnson_step
            assign w_step = dir ? {~r_count[0], r_count[WIDTH-1:1]}
                                : {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
        end
    endgenerate

    shift_counter_decode #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_decode (
        .count   (r_count),
        .idx     (w_idx),
        .illegal (w_illegal)
    );

    // A legal state at the sequence end always steps across the wrap point.
    assign w_wrap_hit = ~w_illegal & (dir ? (w_idx == '0) : (w_idx == c_LAST));

    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= c_RESET;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= load_val;
            r_wrap  <= 1'b0;
        end else if (en) begin
`ifdef SHIFT_COUNTER_AUTOCORRECT_EN
            if (w_illegal) begin
                r_count <= c_RESET;
                r_wrap  <= 1'b0;
            end else begin
                r_count <= w_step;
                r_wrap  <= w_wrap_hit;
            end
`else
            r_count <= w_step;
            r_wrap  <= w_wrap_hit;
`endif
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign count   = r_count;
    assign idx     = w_idx;
    assign wrap    = r_wrap;
    assign illegal = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_shift_counter_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_counter_gen
// Brief    : Scoreboard bench for shift_counter_gen across widths and modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_counter_gen;

    typedef struct packed {
        logic [2:0]  inst;
        logic [31:0] cnt;
        logic [5:0]  idx;
        logic        wrap;
        logic        ill;
    } exp_t;

    localparam logic [2:0] c_J4 = 3'd0, c_R5 = 3'd1, c_J2 = 3'd2,
                           c_R2 = 3'd3, c_J32 = 3'd4, c_R32 = 3'd5;

    logic clk = 1'b0;
    logic clr = 1'b1, en = 1'b0, dir = 1'b0, load = 1'b0;
    logic [3:0]  lv4  = '0;
    logic [4:0]  lv5  = '0;
    logic [1:0]  lv2  = '0;
    logic [31:0] lv32 = '0;

    logic [3:0]  c4;   logic [2:0] x4;   logic w4, l4;
    logic [4:0]  c5;   logic [3:0] x5;   logic w5, l5;
    logic [1:0]  cj2;  logic [1:0] xj2;  logic wj2, lj2;
    logic [1:0]  cr2;  logic [1:0] xr2;  logic wr2, lr2;
    logic [31:0] cj32; logic [5:0] xj32; logic wj32, lj32;
    logic [31:0] cr32; logic [5:0] xr32; logic wr32, lr32;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    shift_counter_gen #(.WIDTH(4), .MODE(0)) u_j4 (.clk(clk), .clr(clr), .en(en), .dir(dir),
        .load(load), .load_val(lv4), .count(c4), .idx(x4), .wrap(w4), .illegal(l4));
    shift_counter_gen #(.WIDTH(5), .MODE(1)) u_r5 (.clk(clk), .clr(clr), .en(en), .dir(dir),
        .load(load), .load_val(lv5), .count(c5), .idx(x5), .wrap(w5), .illegal(l5));
    shift_counter_gen #(.WIDTH(2), .MODE(0)) u_j2 (.clk(clk), .clr(clr), .en(en), .dir(dir),
        .load(load), .load_val(lv2), .count(cj2), .idx(xj2), .wrap(wj2), .illegal(lj2));
    shift_counter_gen #(.WIDTH(2), .MODE(1)) u_r2 (.clk(clk), .clr(clr), .en(en), .dir(dir),
        .load(load), .load_val(lv2), .count(cr2), .idx(xr2), .wrap(wr2), .illegal(lr2));
    shift_counter_gen #(.WIDTH(32), .MODE(0)) u_j32 (.clk(clk), .clr(clr), .en(en), .dir(dir),
        .load(load), .load_val(lv32), .count(cj32), .idx(xj32), .wrap(wj32), .illegal(lj32));
    shift_counter_gen #(.WIDTH(32), .MODE(1)) u_r32 (.clk(clk), .clr(clr), .en(en), .dir(dir),
        .load(load), .load_val(lv32), .count(cr32), .idx(xr32), .wrap(wr32), .illegal(lr32));

    // Johnson state at sequence index k: k low ones, then ones drain out of the bottom.
    function automatic logic [31:0] jexp(input int w, input int k);
        logic [63:0] m, v;
        m = (64'd1 << w) - 64'd1;
        if (k <= w) v = (64'd1 << k) - 64'd1;
        else        v = m & ~((64'd1 << (k - w)) - 64'd1);
        return v[31:0];
    endfunction

    function automatic exp_t mk(input logic [2:0] inst, input logic [31:0] cnt,
                                input int idx, input logic wrap, input logic ill);
        exp_t e;
        e.inst = inst; e.cnt = cnt; e.idx = 6'(idx); e.wrap = wrap; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t observe(input logic [2:0] inst);
        exp_t o;
        o.inst = inst;
        case (inst)
            c_J4:    begin o.cnt = 32'(c4);   o.idx = 6'(x4);   o.wrap = w4;   o.ill = l4;   end
            c_R5:    begin o.cnt = 32'(c5);   o.idx = 6'(x5);   o.wrap = w5;   o.ill = l5;   end
            c_J2:    begin o.cnt = 32'(cj2);  o.idx = 6'(xj2);  o.wrap = wj2;  o.ill = lj2;  end
            c_R2:    begin o.cnt = 32'(cr2);  o.idx = 6'(xr2);  o.wrap = wr2;  o.ill = lr2;  end
            c_J32:   begin o.cnt = cj32;      o.idx = xj32;     o.wrap = wj32; o.ill = lj32; end
            default: begin o.cnt = cr32;      o.idx = xr32;     o.wrap = wr32; o.ill = lr32; end
        endcase
        return o;
    endfunction

    task automatic do_clr();
        clr = 1'b1; en = 1'b0; load = 1'b0; dir = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, o;
        clr = 1'b1;
        sb.push_back(mk(c_J4, 32'h0, 0, 1'b0, 1'b0));
        sb.push_back(mk(c_R5, 32'h1, 0, 1'b0, 1'b0));
        @(posedge clk); #1;
        clr = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = observe(e.inst); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL reset inst%0d: got cnt=%h idx=%0d wrap=%b ill=%b, want cnt=%h idx=%0d wrap=%b ill=%b",
                         e.inst, o.cnt, o.idx, o.wrap, o.ill, e.cnt, e.idx, e.wrap, e.ill);
            end
        end
    endtask

    task automatic test_johnson_up();
        logic [3:0] seq [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                4'b1100, 4'b1000, 4'b0000, 4'b0001};
        exp_t e, o;
        do_clr();
        en = 1'b1; dir = 1'b0;
        for (int k = 0; k < 9; k++) begin
            sb.push_back(mk(c_J4, 32'(seq[k]), (k + 1) % 8, (k == 7), 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(e.inst); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL johnson_up step%0d: got cnt=%h idx=%0d wrap=%b ill=%b, want cnt=%h idx=%0d wrap=%b ill=%b",
                         k + 1, o.cnt, o.idx, o.wrap, o.ill, e.cnt, e.idx, e.wrap, e.ill);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_johnson_down_flip();
        exp_t e, o;
        do_clr();
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dir = (k < 2);
            case (k)
                0:       sb.push_back(mk(c_J4, 32'b1000, 7, 1'b1, 1'b0));
                1:       sb.push_back(mk(c_J4, 32'b1100, 6, 1'b0, 1'b0));
                default: sb.push_back(mk(c_J4, 32'b1000, 7, 1'b0, 1'b0));
            endcase
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(e.inst); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL johnson_down step%0d: got cnt=%h idx=%0d wrap=%b ill=%b, want cnt=%h idx=%0d wrap=%b ill=%b",
                         k, o.cnt, o.idx, o.wrap, o.ill, e.cnt, e.idx, e.wrap, e.ill);
            end
        end
        en = 1'b0; dir = 1'b0;
    endtask

    task automatic test_ring();
        exp_t e, o;
        do_clr();
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            dir = (k == 6);
            if (k <= 5) sb.push_back(mk(c_R5, 32'd1 << (k % 5), k % 5, (k == 5), 1'b0));
            else        sb.push_back(mk(c_R5, 32'b10000, 4, 1'b1, 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(e.inst); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL ring step%0d: got cnt=%h idx=%0d wrap=%b ill=%b, want cnt=%h idx=%0d wrap=%b ill=%b",
                         k, o.cnt, o.idx, o.wrap, o.ill, e.cnt, e.idx, e.wrap, e.ill);
            end
        end
        en = 1'b0; dir = 1'b0;
    endtask

    task automatic test_priority();
        exp_t e, o;
        do_clr();
        for (int k = 0; k < 6; k++) begin
            clr  = (k == 0);
            load = (k < 2) || (k == 4) || (k == 5);
            en   = (k < 2) || (k >= 4);
            case (k)
                0: begin lv4 = 4'b1111; sb.push_back(mk(c_J4, 32'b0000, 0, 1'b0, 1'b0)); end
                1: begin lv4 = 4'b0110; sb.push_back(mk(c_J4, 32'b0110, 0, 1'b0, 1'b1)); end
                2, 3:    sb.push_back(mk(c_J4, 32'b0110, 0, 1'b0, 1'b1));
                4: begin lv4 = 4'b1000; sb.push_back(mk(c_J4, 32'b1000, 7, 1'b0, 1'b0)); end
                default: begin lv4 = 4'b0011; sb.push_back(mk(c_J4, 32'b0011, 2, 1'b0, 1'b0)); end
            endcase
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(e.inst); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL priority cyc%0d: got cnt=%h idx=%0d wrap=%b ill=%b, want cnt=%h idx=%0d wrap=%b ill=%b",
                         k, o.cnt, o.idx, o.wrap, o.ill, e.cnt, e.idx, e.wrap, e.ill);
            end
        end
        clr = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_illegal();
        exp_t e, o;
        do_clr();
        for (int k = 0; k < 3; k++) begin
            load = (k == 0); en = (k > 0); lv4 = 4'b0101;
            if (k == 0) sb.push_back(mk(c_J4, 32'b0101, 0, 1'b0, 1'b1));
`ifdef SHIFT_COUNTER_AUTOCORRECT_EN
            else if (k == 1) sb.push_back(mk(c_J4, 32'b0000, 0, 1'b0, 1'b0));
            else             sb.push_back(mk(c_J4, 32'b0001, 1, 1'b0, 1'b0));
`else
            else if (k == 1) sb.push_back(mk(c_J4, 32'b1011, 0, 1'b0, 1'b1));
            else             sb.push_back(mk(c_J4, 32'b0110, 0, 1'b0, 1'b1));
`endif
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(e.inst); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL illegal cyc%0d: got cnt=%h idx=%0d wrap=%b ill=%b, want cnt=%h idx=%0d wrap=%b ill=%b",
                         k, o.cnt, o.idx, o.wrap, o.ill, e.cnt, e.idx, e.wrap, e.ill);
            end
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_width_sweep();
        exp_t e, o;
        do_clr();
        en = 1'b1; dir = 1'b0;
        for (int k = 1; k <= 66; k++) begin
            sb.push_back(mk(c_J2,  jexp(2, k % 4),     k % 4,  (k % 4)  == 0, 1'b0));
            sb.push_back(mk(c_R2,  32'd1 << (k % 2),   k % 2,  (k % 2)  == 0, 1'b0));
            sb.push_back(mk(c_J32, jexp(32, k % 64),   k % 64, (k % 64) == 0, 1'b0));
            sb.push_back(mk(c_R32, 32'd1 << (k % 32),  k % 32, (k % 32) == 0, 1'b0));
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); o = observe(e.inst); tests++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL sweep inst%0d step%0d: got cnt=%h idx=%0d wrap=%b ill=%b, want cnt=%h idx=%0d wrap=%b ill=%b",
                             e.inst, k, o.cnt, o.idx, o.wrap, o.ill, e.cnt, e.idx, e.wrap, e.ill);
                end
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_johnson_up();
        test_johnson_down_flip();
        test_ring();
        test_priority();
        test_illegal();
        test_width_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
